// File: rtl/midi_rx_pkg.sv
// Shared MIDI receive definitions: FSM state encoding, line constants and
// the 2-of-3 vote used for bit sampling. MIDI_STATUS_MASK is shared with the
// downstream parser.
package midi_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int         MIDI_BAUD         = 31250;
  localparam int         MIDI_OVERSAMPLE   = 16;
  localparam logic [7:0] MIDI_ACTIVE_SENSE = 8'hFE;
  localparam logic [7:0] MIDI_STATUS_MASK  = 8'h80;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/midi_rx_fifo.sv
// First-word-fall-through byte buffer between the MIDI receiver and parser.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (flushes the buffer)
//   push_i/data_i  write one byte; dropped with ovf_o pulse if full and no pop
//   pop_i          consume head byte (ignored while empty)
//   data_o         head byte, forced to 0 while empty
//   valid_o        buffer not empty
//   ovf_o          one-cycle pulse: push lost because the buffer was full
module midi_rx_fifo
  import midi_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [7:0]  mem_q [DEPTH];
  logic        ovf_q, ovf_d;
  logic        empty, full, do_pop, do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wp_d  = wp_q + (AW+1)'(do_push);
    rp_d  = rp_q + (AW+1)'(do_pop);
    ovf_d = push_i & full & ~do_pop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
  end

  assign data_o  = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];
  assign valid_o = ~empty;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1 at BAUD, 16x oversampled, 3-sample majority per
// bit, start-glitch rejection, framing-error/break handling and a FWFT byte
// buffer with valid/ready output.
// Ports:
//   IN_CLOCK       system clock
//   IN_RESET       async active-high reset (released synchronously inside)
//   IN_UART        raw MIDI line, idle high, asynchronous
//   OUT_BYTE       buffer head byte, valid while OUT_VALID
//   OUT_VALID      buffer not empty
//   IN_READY       consumer takes OUT_BYTE when OUT_VALID & IN_READY
//   OUT_FRAME_ERR  one-cycle pulse: stop bit sampled low
//   OUT_OVERFLOW   one-cycle pulse: byte dropped, buffer full
// Build option: MIDI_RX_ACTIVE_SENSE_FILTER_EN drops received 8'hFE bytes
// before they reach the buffer.
module midi_uart_rx
  import midi_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int OVERSAMPLE = MIDI_OVERSAMPLE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       IN_CLOCK,
  input  logic       IN_RESET,
  input  logic       IN_UART,
  output logic [7:0] OUT_BYTE,
  output logic       OUT_VALID,
  input  logic       IN_READY,
  output logic       OUT_FRAME_ERR,
  output logic       OUT_OVERFLOW
);

  localparam int             DIV      = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);

  // Reset asserts immediately, releases on a clock edge.
  logic [1:0] rst_pipe_q;
  logic       rst;

  always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
    if (IN_RESET) rst_pipe_q <= 2'b11;
    else          rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end
  assign rst = rst_pipe_q[1];

  // Line synchronizer, preset to idle level.
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge IN_CLOCK or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], IN_UART};
  end
  assign rx_s = sync_q[1];

  rx_state_t  state_q;
  logic [3:0] phase_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       s7_q, s8_q;
  logic [3:0] brk_q;
  logic       push_q, ferr_q;
  logic       maj, keep, start_entry, tick;
  logic [CW-1:0] div_q;

  // Prescaler restarts on the falling start edge so ticks align to the frame.
  assign start_entry = (state_q == IDLE) && !rx_s;
  assign tick        = (div_q == DIV_LAST);

  always_ff @(posedge IN_CLOCK or posedge rst) begin
    if (rst)                       div_q <= '0;
    else if (start_entry || tick)  div_q <= '0;
    else                           div_q <= div_q + CW'(1);
  end

  // Samples from phases 7 and 8 are held; the vote completes with phase 9.
  assign maj = maj3(s7_q, s8_q, rx_s);

`ifdef MIDI_RX_ACTIVE_SENSE_FILTER_EN
  assign keep = (shift_q != MIDI_ACTIVE_SENSE);
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge IN_CLOCK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      brk_q   <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      if (tick && (state_q == DATA || state_q == STOP)) begin
        if (phase_q == 4'd7) s7_q <= rx_s;
        if (phase_q == 4'd8) s8_q <= rx_s;
      end
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            phase_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (phase_q == 4'd8) begin
              if (rx_s) begin
                state_q <= IDLE;     // too short to be a start bit
              end else begin
                state_q <= DATA;
                phase_q <= '0;
                bit_q   <= '0;
              end
            end else begin
              phase_q <= phase_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd9) shift_q <= {maj, shift_q[7:1]};  // LSB first
            if (phase_q == 4'd15) begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd9) begin
              if (maj) begin
                push_q  <= keep;
                state_q <= IDLE;
              end else begin
                ferr_q  <= 1'b1;
                brk_q   <= '0;
                state_q <= BREAK;
              end
            end
          end
        end
        BREAK: begin
          // Wait out a held-low line so a break yields a single error.
          if (tick) begin
            if (!rx_s)                brk_q   <= '0;
            else if (brk_q == 4'd15)  state_q <= IDLE;
            else                      brk_q   <= brk_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  midi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (IN_CLOCK),
    .rst_i   (rst),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (IN_READY),
    .data_o  (OUT_BYTE),
    .valid_o (OUT_VALID),
    .ovf_o   (OUT_OVERFLOW)
  );

  assign OUT_FRAME_ERR = ferr_q;

endmodule
